traffic_scheduler: RTL and testbench

Request scheduler that sits in front of the traffic light controller and drives its mode inputs (Cm, Cc) and pedestrian-queue inputs (PQm, PQc). It latches pedestrian and queue requests for the main and cross roads and ages them in seconds. It arbitrates between them with starvation protection and changes mode only inside a safe window of the controller's countdown. It observes the controller's phase and countdown outputs to detect when a request has been served.

---
 rtl/traffic_pkg.sv | 35 +++
 rtl/req_ager.sv | 38 +++
 rtl/traffic_scheduler.sv | 129 ++++++++++++
 tb/tb_traffic_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared constants and types for the traffic light request scheduler.
// Phase encodings, mode-state encodings {Cm,Cc} and arbitration helper.
package traffic_pkg;

  localparam int CNT_W        = 5;
  localparam int DEF_MAX_WAIT = 24;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  typedef logic [1:0] mode_t;

  localparam mode_t IDLE      = 2'b00;
  localparam mode_t MAIN_PRI  = 2'b10;
  localparam mode_t CROSS_PRI = 2'b01;
  localparam mode_t PEAK      = 2'b11;

  // Older side wins; a tie goes to the side not granted last.
  function automatic mode_t arbitrate(
    input logic m_older,
    input logic c_older,
    input logic lg_cross
  );
    if (m_older)
      return MAIN_PRI;
    else if (c_older)
      return CROSS_PRI;
    else if (lg_cross)
      return MAIN_PRI;
    else
      return CROSS_PRI;
  endfunction

endpackage

// File: rtl/req_ager.sv
// One pending-request latch with saturating age counter and served pulse.
// A new request wins over a same-cycle clear and restarts the age.
module req_ager
  import traffic_pkg::*;
#(
  parameter int AGE_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             req,
  input  logic             clr,
  output logic             pend,
  output logic [AGE_W-1:0] age,
  output logic             served
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend   <= 1'b0;
      age    <= '0;
      served <= 1'b0;
    end else begin
      served <= clr & pend;
      if (req)
        pend <= 1'b1;
      else if (clr)
        pend <= 1'b0;
      if (!pend || clr)
        age <= '0;
      else if (tick && age != AGE_MAX)
        age <= age + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_scheduler.sv
// Request scheduler driving the light controller mode and queue inputs.
// Optional peak-hour mode enabled by defining TRAFFIC_SCHED_PEAK_EN.
module traffic_scheduler
  import traffic_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int AGE_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             req_main,
  input  logic             req_cross,
  input  logic             peak,
  input  logic             online,
  input  logic [1:0]       phase,
  input  logic [CNT_W-1:0] countdown,
  output logic             Cm,
  output logic             Cc,
  output logic             PQm,
  output logic             PQc,
  output logic             served_main,
  output logic             served_cross
);

  localparam logic [AGE_W-1:0] LIMIT = AGE_W'(MAX_WAIT);

  logic [1:0]       phase_q;
  logic             clr_m;
  logic             clr_c;
  logic             window;
  logic             pend_m;
  logic             pend_c;
  logic [AGE_W-1:0] age_m;
  logic [AGE_W-1:0] age_c;
  logic             lg_cross;
  logic             starve_m;
  logic             starve_c;
  logic             m_older;
  logic             c_older;
  mode_t            state;
  mode_t            nxt;

`ifndef TRAFFIC_SCHED_PEAK_EN
  logic unused_peak;
  assign unused_peak = peak;
`endif

  assign clr_m  = (phase_q == GREEN) && (phase == YELLOW);
  assign clr_c  = (phase_q == RED) && (phase == GREEN);
  assign window = tick && (countdown > CNT_W'(1));

  req_ager #(.AGE_W(AGE_W)) u_main (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .req    (req_main),
    .clr    (clr_m),
    .pend   (pend_m),
    .age    (age_m),
    .served (served_main)
  );

  req_ager #(.AGE_W(AGE_W)) u_cross (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .req    (req_cross),
    .clr    (clr_c),
    .pend   (pend_c),
    .age    (age_c),
    .served (served_cross)
  );

  assign starve_m = age_m >= LIMIT;
  assign starve_c = age_c >= LIMIT;
  assign m_older  = age_m > age_c;
  assign c_older  = age_c > age_m;

  always_comb begin
    nxt = IDLE;
    if (online)
      nxt = IDLE;
    else if (starve_m && starve_c)
      nxt = arbitrate(m_older, c_older, lg_cross);
    else if (starve_m)
      nxt = MAIN_PRI;
    else if (starve_c)
      nxt = CROSS_PRI;
`ifdef TRAFFIC_SCHED_PEAK_EN
    else if (peak)
      nxt = PEAK;
`endif
    else if (pend_m && pend_c)
      nxt = arbitrate(m_older, c_older, lg_cross);
    else if (pend_m)
      nxt = MAIN_PRI;
    else if (pend_c)
      nxt = CROSS_PRI;
    else
      nxt = IDLE;
  end

  // Mode only moves inside the window so it is stable at countdown expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lg_cross <= 1'b0;
      phase_q  <= GREEN;
      PQm      <= 1'b0;
      PQc      <= 1'b0;
    end else begin
      phase_q <= phase;
      PQm     <= pend_m & ~online;
      PQc     <= pend_c & ~online;
      if (window) begin
        state <= nxt;
        if (nxt == MAIN_PRI)
          lg_cross <= 1'b0;
        else if (nxt == CROSS_PRI)
          lg_cross <= 1'b1;
      end
    end
  end

  assign Cm = state[1];
  assign Cc = state[0];

endmodule

// File: tb/tb_traffic_scheduler.sv
// Directed self-checking bench for traffic_scheduler.
// Expectations follow TRAFFIC_SCHED_PEAK_EN when the macro is defined.
module tb_traffic_scheduler;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       req_main;
  logic       req_cross;
  logic       peak;
  logic       online;
  logic [1:0] phase;
  logic [4:0] countdown;
  logic       Cm;
  logic       Cc;
  logic       PQm;
  logic       PQc;
  logic       served_main;
  logic       served_cross;

  int total;
  int passed;
  int failed;

  logic [1:0] peak_mode;
  logic [1:0] peak_cross;

  traffic_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .req_main     (req_main),
    .req_cross    (req_cross),
    .peak         (peak),
    .online       (online),
    .phase        (phase),
    .countdown    (countdown),
    .Cm           (Cm),
    .Cc           (Cc),
    .PQm          (PQm),
    .PQc          (PQc),
    .served_main  (served_main),
    .served_cross (served_cross)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick(input logic [4:0] cd);
    countdown = cd;
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic ticks(input int n, input logic [4:0] cd);
    for (int i = 0; i < n; i++) do_tick(cd);
  endtask

  task automatic raise(input logic m, input logic c);
    req_main  = m;
    req_cross = c;
    cyc(1);
    req_main  = 1'b0;
    req_cross = 1'b0;
  endtask

  task automatic set_phase(input logic [1:0] p);
    phase = p;
    cyc(1);
  endtask

  function automatic logic [3:0] mode();
    return {2'b00, Cm, Cc};
  endfunction

  function automatic logic [3:0] pq();
    return {2'b00, PQm, PQc};
  endfunction

  function automatic logic [3:0] srv();
    return {2'b00, served_main, served_cross};
  endfunction

  initial begin
    total = 0;
    passed = 0;
    failed = 0;
`ifdef TRAFFIC_SCHED_PEAK_EN
    peak_mode  = 2'b11;
    peak_cross = 2'b11;
`else
    peak_mode  = 2'b00;
    peak_cross = 2'b01;
`endif
    rst = 1'b1;
    tick = 1'b0;
    req_main = 1'b0;
    req_cross = 1'b0;
    peak = 1'b0;
    online = 1'b0;
    phase = 2'b00;
    countdown = 5'd16;
    cyc(2);
    chk("rst_mode", mode(), 4'b0000);
    chk("rst_pq", pq(), 4'b0000);
    chk("rst_served", srv(), 4'b0000);
    rst = 1'b0;
    cyc(1);

    for (int i = 0; i < 20; i++) begin
      do_tick(5'd16);
      chk("idle_ticks", {Cm, Cc, PQm, PQc}, 4'b0000);
    end

    raise(1'b1, 1'b0);
    chk("pqm_n1", pq(), 4'b0000);
    cyc(1);
    chk("pqm_n2", pq(), 4'b0010);
    do_tick(5'd10);
    chk("main_pri", mode(), 4'b0010);
    set_phase(2'b01);
    chk("served_m", srv(), 4'b0010);
    cyc(1);
    chk("served_m_end", srv(), 4'b0000);
    chk("pqm_clr", pq(), 4'b0000);
    chk("mode_hold", mode(), 4'b0010);
    do_tick(5'd10);
    chk("idle_after", mode(), 4'b0000);
    set_phase(2'b10);

    raise(1'b1, 1'b1);
    cyc(1);
    do_tick(5'd10);
    chk("rr_cross", mode(), 4'b0001);
    set_phase(2'b00);
    chk("served_c", srv(), 4'b0001);
    set_phase(2'b01);
    chk("served_m2", srv(), 4'b0010);
    set_phase(2'b10);
    raise(1'b1, 1'b1);
    cyc(1);
    do_tick(5'd10);
    chk("rr_main", mode(), 4'b0010);

    set_phase(2'b00);
    chk("served_c2", srv(), 4'b0001);
    phase = 2'b01;
    req_main = 1'b1;
    cyc(1);
    req_main = 1'b0;
    chk("set_clr_srv", srv(), 4'b0010);
    cyc(2);
    chk("set_clr_pq", pq(), 4'b0010);

    set_phase(2'b10);
    set_phase(2'b00);
    set_phase(2'b01);
    raise(1'b0, 1'b1);
    cyc(1);
    do_tick(5'd1);
    chk("cd1_hold", mode(), 4'b0010);
    do_tick(5'd0);
    chk("cd0_hold", mode(), 4'b0010);
    do_tick(5'd16);
    chk("cd16_upd", mode(), 4'b0001);

    ticks(20, 5'd1);
    chk("age_hold", mode(), 4'b0001);
    peak = 1'b1;
    do_tick(5'd16);
    chk("peak_a23", mode(), {2'b00, peak_cross});
    do_tick(5'd16);
    chk("starve_c", mode(), 4'b0001);
    set_phase(2'b10);
    set_phase(2'b00);
    chk("served_c3", srv(), 4'b0001);
    cyc(1);
    do_tick(5'd16);
    chk("peak_idle", mode(), {2'b00, peak_mode});
    peak = 1'b0;
    do_tick(5'd16);
    chk("peak_off", mode(), 4'b0000);

    raise(1'b1, 1'b1);
    cyc(1);
    chk("pq_both", pq(), 4'b0011);
    do_tick(5'd16);
    chk("rr_main2", mode(), 4'b0010);
    ticks(3, 5'd1);
    online = 1'b1;
    cyc(1);
    chk("online_pq", pq(), 4'b0000);
    do_tick(5'd16);
    chk("online_mode", mode(), 4'b0000);
    ticks(2, 5'd1);
    online = 1'b0;
    cyc(1);
    chk("online_off_pq", pq(), 4'b0011);
    ticks(17, 5'd1);
    do_tick(5'd16);
    chk("starve_rr", mode(), 4'b0001);

    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {Cm, Cc, PQm, PQc}, 4'b0000);
    rst = 1'b0;
    cyc(2);
    chk("post_rst_pq", pq(), 4'b0000);
    do_tick(5'd16);
    chk("post_rst_mode", mode(), 4'b0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
